// File: rtl/rsa_host_link.sv
// Host-side link engine for the RSA UART protocol: serializes {key, mod, plaintext}
// into a 12-byte TX frame, then collects the 4-byte ciphertext reply into result.
module rsa_host_link #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WordSize-1:0] key,
    input  logic [WordSize-1:0] mod,
    input  logic [WordSize-1:0] plaintext,
    output logic [7:0]          tx_data,
    output logic                tx_wrreq,
    input  logic                tx_full,
    input  logic [7:0]          rx_data,
    output logic                rx_rdreq,
    input  logic                rx_empty,
    output logic [WordSize-1:0] result,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    localparam int FrameBits = 3 * WordSize;
    localparam int TxBytes   = FrameBits / 8;
    localparam int RxBytes   = WordSize / 8;
    localparam logic [3:0] TxLast = 4'(TxBytes - 1);
    localparam logic [3:0] RxLast = 4'(RxBytes - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [FrameBits-1:0] sh;
    logic [3:0]           cnt;

    // FIFO strobes: a byte moves on every rising edge where the strobe is high.
    // The strobe is only raised when the FIFO side can accept (tx_full=0) or
    // offers (rx_empty=0) a byte, so the strobe itself is the transfer event.
    assign tx_wrreq  = (state == SEND) && !tx_full;
    assign rx_rdreq  = (state == RECV) && !rx_empty;
    assign tx_data   = sh[FrameBits-1 -: 8];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= {key, mod, plaintext};
                        cnt   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_full) begin
                        sh <= {sh[FrameBits-9:0], 8'h00};
                        if (cnt == TxLast) begin
                            cnt   <= '0;
                            state <= RECV;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                RECV: begin
                    // The frame has fully shifted out, so the low word is free for assembly.
                    if (!rx_empty) begin
                        sh[WordSize-1:0] <= {sh[WordSize-9:0], rx_data};
                        if (cnt == RxLast) begin
                            result <= {sh[WordSize-9:0], rx_data};
                            cnt    <= '0;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_link.sv
// Directed bench for rsa_host_link: FIFO models around the DUT, a linear
// sequence of transactions, and immediate assertions at each comparison.
module tb_rsa_host_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] key, mod, plaintext;
    logic [7:0]  tx_data;
    logic        tx_wrreq;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_rdreq;
    logic        rx_empty;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rsa_host_link #(.WordSize(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .mod       (mod),
        .plaintext (plaintext),
        .tx_data   (tx_data),
        .tx_wrreq  (tx_wrreq),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_rdreq  (rx_rdreq),
        .rx_empty  (rx_empty),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Cycle bookkeeping: rel is the cycle number relative to the start edge.
    int cyc = 0;
    int t0 = 0;
    int rel;
    int full_lo = 1, full_hi = 0;
    int hold_lo = 1, hold_hi = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always_comb rel = cyc - t0;

    // TX FIFO model: flag from a cycle window, bytes logged on each write.
    logic [7:0] tx_log[$];
    int viol = 0;
    assign tx_full = (rel >= full_lo) && (rel <= full_hi);
    always @(negedge clk) begin
        if (tx_wrreq) tx_log.push_back(tx_data);
        if ((tx_wrreq && tx_full) || (rx_rdreq && rx_empty)) viol <= viol + 1;
    end

    // RX FIFO model: show-ahead memory, optionally held empty in a cycle window.
    logic [7:0] rx_mem[0:63];
    int rx_wr = 0;
    int rx_rd = 0;
    assign rx_empty = (rx_rd == rx_wr) || ((rel >= hold_lo) && (rel <= hold_hi));
    assign rx_data  = rx_mem[rx_rd[5:0]];
    always @(posedge clk) if (rx_rdreq) rx_rd <= rx_rd + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_rx(input logic [7:0] b0, b1, b2, b3);
        rx_mem[rx_wr[5:0]] = b0; rx_wr++;
        rx_mem[rx_wr[5:0]] = b1; rx_wr++;
        rx_mem[rx_wr[5:0]] = b2; rx_wr++;
        rx_mem[rx_wr[5:0]] = b3; rx_wr++;
    endtask

    task automatic check_bytes(input string tag, input int base, input logic [7:0] exp_q[$]);
        logic [7:0] got;
        check({tag, "_len"}, 32'(tx_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < 12; i++) begin
            got = (base + i < tx_log.size()) ? tx_log[base + i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'h0, got}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic frame_of(input logic [31:0] k, m, p, output logic [7:0] q[$]);
        logic [95:0] f;
        f = {k, m, p};
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(f[95 - 8*i -: 8]);
    endtask

    // One transaction: start accepted at edge 0, then observe each cycle until done.
    task automatic run_txn(input logic [31:0] k, m, p, input bit poke,
                           output int done_cyc, output int done_cnt,
                           output int busy_cnt, output logic [31:0] pre_res);
        @(posedge clk); #1;
        key = k; mod = m; plaintext = p; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        key = $urandom; mod = $urandom; plaintext = $urandom;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0; pre_res = 'x;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (poke) begin
                start = (n == 5 || n == 15);
                if (start) begin
                    key = 32'hFFFF_0000 | 32'(n); mod = 32'hEEEE_EEEE; plaintext = 32'hDDDD_DDDD;
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc < 0 && !done) pre_res = result;
            if (done_cyc >= 0 && n >= done_cyc + 5) break;
        end
        start = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_q[$];
        int          base, v0, dc, dn, bc;
        logic [31:0] pr;

        reset = 1'b1; start = 1'b0; key = '0; mod = '0; plaintext = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data",  {24'h0, tx_data}, 32'h0);
        check("rst_result",   result,           32'h0);
        check("rst_busy",     {31'h0, busy},    32'h0);
        check("rst_done",     {31'h0, done},    32'h0);
        check("rst_tx_wrreq", {31'h0, tx_wrreq}, 32'h0);
        check("rst_rx_rdreq", {31'h0, rx_rdreq}, 32'h0);
        check("rst_state",    {30'h0, state_dbg}, 32'h0);
        reset = 1'b0;

        // Basic frame, no stalls.
        base = tx_log.size();
        load_rx(8'h12, 8'h34, 8'h56, 8'h78);
        run_txn(32'h0001_0001, 32'h0D1C_2B3A, 32'h0000_0041, 1'b0, dc, dn, bc, pr);
        exp_q = {8'h00, 8'h01, 8'h00, 8'h01, 8'h0D, 8'h1C, 8'h2B, 8'h3A,
                 8'h00, 8'h00, 8'h00, 8'h41};
        check_bytes("basic", base, exp_q);
        check("basic_result",   result,    32'h1234_5678);
        check("basic_done_cyc", 32'(dc),   32'd17);
        check("basic_done_cnt", 32'(dn),   32'd1);
        check("basic_busy_cyc", 32'(bc),   32'd17);
        check("basic_pre_res",  pr,        32'h0);
        check("basic_busy_end", {31'h0, busy}, 32'h0);

        // TX backpressure in cycles 3..7.
        base = tx_log.size(); v0 = viol;
        full_lo = 3; full_hi = 7;
        load_rx(8'h01, 8'h02, 8'h03, 8'h04);
        run_txn(32'hA5A5_0003, 32'hC0FF_EE11, 32'h0BAD_F00D, 1'b0, dc, dn, bc, pr);
        full_lo = 1; full_hi = 0;
        frame_of(32'hA5A5_0003, 32'hC0FF_EE11, 32'h0BAD_F00D, exp_q);
        check_bytes("txbp", base, exp_q);
        check("txbp_result",   result,       32'h0102_0304);
        check("txbp_done_cyc", 32'(dc),      32'd22);
        check("txbp_pre_res",  pr,           32'h1234_5678);
        check("txbp_viol",     32'(viol - v0), 32'd0);

        // RX starvation: empty for 50 cycles after SEND.
        base = tx_log.size(); v0 = viol;
        hold_lo = 13; hold_hi = 62;
        load_rx(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        run_txn(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 1'b0, dc, dn, bc, pr);
        hold_lo = 1; hold_hi = 0;
        frame_of(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, exp_q);
        check_bytes("rxst", base, exp_q);
        check("rxst_result",   result,         32'hDEAD_BEEF);
        check("rxst_done_cyc", 32'(dc),        32'd67);
        check("rxst_viol",     32'(viol - v0), 32'd0);
        check("rxst_rx_level", 32'(rx_wr - rx_rd), 32'd0);

        // Start pulses while busy are ignored.
        base = tx_log.size();
        load_rx(8'h0F, 8'h1E, 8'h2D, 8'h3C);
        run_txn(32'hCAFE_BABE, 32'h8BAD_F00D, 32'h0000_0007, 1'b1, dc, dn, bc, pr);
        frame_of(32'hCAFE_BABE, 32'h8BAD_F00D, 32'h0000_0007, exp_q);
        check_bytes("sbusy", base, exp_q);
        check("sbusy_result",   result,  32'h0F1E_2D3C);
        check("sbusy_done_cyc", 32'(dc), 32'd17);
        check("sbusy_done_cnt", 32'(dn), 32'd1);

        // Reset after the 6th write of a frame.
        base = tx_log.size();
        @(posedge clk); #1;
        key = 32'h7777_7777; mod = 32'h6666_6666; plaintext = 32'h5555_5555; start = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_busy",     {31'h0, busy},      32'h0);
        check("mid_tx_wrreq", {31'h0, tx_wrreq},  32'h0);
        check("mid_tx_data",  {24'h0, tx_data},   32'h0);
        check("mid_result",   result,             32'h0);
        check("mid_state",    {30'h0, state_dbg}, 32'h0);
        check("mid_tx_count", 32'(tx_log.size() - base), 32'd6);
        @(posedge clk); #1 reset = 1'b0;

        base = tx_log.size();
        load_rx(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        run_txn(32'h0123_4567, 32'h89AB_CDEF, 32'h0246_8ACE, 1'b0, dc, dn, bc, pr);
        frame_of(32'h0123_4567, 32'h89AB_CDEF, 32'h0246_8ACE, exp_q);
        check_bytes("after_rst", base, exp_q);
        check("after_rst_pre_res",  pr,      32'h0);
        check("after_rst_result",   result,  32'hA1B2_C3D4);
        check("after_rst_done_cyc", 32'(dc), 32'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
